// File: rtl/isp_counter_pkg.sv
// isp_counter_pkg: register map, CTRL/STATUS bit positions and mode encodings
package isp_counter_pkg;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam int CTRL_EN        = 0;
    localparam int CTRL_DIR       = 1;
    localparam int CTRL_MODE      = 2;
    localparam int CTRL_IRQ_MATCH = 4;
    localparam int CTRL_IRQ_OVF   = 5;
    localparam int CTRL_W         = 6;
    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;
    typedef enum logic [1:0] {
        MODE_FREE       = 2'd0,
        MODE_MODULO     = 2'd1,
        MODE_ONESHOT    = 2'd2,
        MODE_FREE_ALIAS = 2'd3
    } mode_e;
endpackage

// File: rtl/isp_counter_chan.sv
// isp_counter_chan: one counter channel with CTRL/COUNT/COMPARE/STATUS and step logic
module isp_counter_chan
    import isp_counter_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ctrl,
    input  logic              wr_count,
    input  logic              wr_compare,
    input  logic              wr_status,
    input  logic [BITS-1:0]   wmask,
    input  logic [BITS-1:0]   wdata,
    input  logic [BITS-1:0]   la_write,
    input  logic [BITS-1:0]   la_input,
    output logic [CTRL_W-1:0] ctrl,
    output logic [BITS-1:0]   count,
    output logic [BITS-1:0]   compare,
    output logic [1:0]        status,
    output logic              irq
);
    function automatic logic [BITS-1:0] merge(input logic [BITS-1:0] old, input logic [BITS-1:0] nw,
                                              input logic [BITS-1:0] m);
        return (old & ~m) | (nw & m);
    endfunction
    logic dir, la_load, step, at_cmp, at_zero, at_max, os_done;
    mode_e mode;
    logic [BITS-1:0] inc, cnt_next;
    logic [1:0] set, clr;
    assign dir     = ctrl[CTRL_DIR];
    assign mode    = mode_e'(ctrl[CTRL_MODE +: 2]);
    assign la_load = |la_write;
    assign step    = ctrl[CTRL_EN] & ~wr_count & ~la_load;
    assign at_cmp  = count == compare;
    assign at_zero = count == '0;
    assign at_max  = &count;
    assign inc     = dir ? count - BITS'(1) : count + BITS'(1);
    assign clr     = wr_status ? wdata[1:0] & wmask[1:0] : 2'b00;
    assign irq     = (status[STAT_MATCH] & ctrl[CTRL_IRQ_MATCH]) | (status[STAT_OVF] & ctrl[CTRL_IRQ_OVF]);
    always_comb begin
        cnt_next = inc;
        set      = '0;
        os_done  = 1'b0;
        if (mode == MODE_MODULO) begin
            cnt_next        = dir ? (at_zero ? compare : inc) : (at_cmp ? '0 : inc);
            set[STAT_MATCH] = dir ? at_zero : at_cmp;
        end else if (mode == MODE_ONESHOT && at_cmp) begin
            cnt_next        = count;
            set[STAT_MATCH] = 1'b1;
            os_done         = 1'b1;
        end else begin
            set[STAT_OVF]   = dir ? at_zero : at_max;
            set[STAT_MATCH] = at_cmp;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= '1;
            status  <= '0;
        end else begin
            ctrl    <= wr_ctrl ? (ctrl & ~wmask[CTRL_W-1:0]) | (wdata[CTRL_W-1:0] & wmask[CTRL_W-1:0])
                     : (step & os_done) ? ctrl & ~(CTRL_W'(1) << CTRL_EN) : ctrl;
            count   <= wr_count ? merge(count, wdata, wmask)
                     : la_load ? merge(count, la_input, la_write)
                     : step ? cnt_next : count;
            compare <= wr_compare ? merge(compare, wdata, wmask) : compare;
            status  <= (status & ~clr) | (step ? set : 2'b00);
        end
    end
endmodule

// File: rtl/isp_counter_bank.sv
// isp_counter_bank: bus decode, one-wait-state handshake, read mux and irq over counter channels
module isp_counter_bank
    import isp_counter_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int CHANNELS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    output logic                     ready,
    input  logic [7:0]               addr,
    input  logic [3:0]               wstrb,
    input  logic [BITS-1:0]          wdata,
    output logic [BITS-1:0]          rdata,
    input  logic [BITS-1:0]          la_write,
    input  logic [BITS-1:0]          la_input,
    output logic [BITS-1:0]          count,
    output logic [CHANNELS*BITS-1:0] count_flat,
    output logic                     irq
);
    logic commit, is_wr, unused_ok;
    logic [3:0] ch;
    logic [1:0] rs;
    logic [BITS-1:0] wmask, rd;
    logic [CTRL_W-1:0] ctrl_a [CHANNELS];
    logic [BITS-1:0] cnt_a [CHANNELS];
    logic [BITS-1:0] cmp_a [CHANNELS];
    logic [1:0] st_a [CHANNELS];
    logic [CHANNELS-1:0] irq_v;
    assign commit    = valid & ~ready;
    assign is_wr     = |wstrb;
    assign ch        = addr[7:4];
    assign rs        = addr[3:2];
    assign unused_ok = ^addr[1:0];
    assign count     = cnt_a[0];
    assign irq       = |irq_v;
    always_comb begin
        for (int k = 0; k < BITS; k++) wmask[k] = wstrb[k/8];
    end
    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic hit;
        assign hit = commit & is_wr & (ch == 4'(n));
        isp_counter_chan #(.BITS(BITS)) u_chan (
            .clk        (clk),
            .reset      (reset),
            .wr_ctrl    (hit && rs == REG_CTRL),
            .wr_count   (hit && rs == REG_COUNT),
            .wr_compare (hit && rs == REG_COMPARE),
            .wr_status  (hit && rs == REG_STATUS),
            .wmask      (wmask),
            .wdata      (wdata),
            .la_write   (n == 0 ? la_write : '0),
            .la_input   (la_input),
            .ctrl       (ctrl_a[n]),
            .count      (cnt_a[n]),
            .compare    (cmp_a[n]),
            .status     (st_a[n]),
            .irq        (irq_v[n])
        );
        assign count_flat[n*BITS +: BITS] = cnt_a[n];
    end
    always_comb begin
        rd = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch == 4'(i))
                rd = rs == REG_CTRL ? BITS'(ctrl_a[i]) : rs == REG_COUNT ? cnt_a[i]
                   : rs == REG_COMPARE ? cmp_a[i] : BITS'(st_a[i]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= commit;
            if (commit) rdata <= rd;
        end
    end
endmodule

// File: tb/tb_isp_counter_bank.sv
// tb_isp_counter_bank: table-driven bus vectors with read scoreboard plus multi-cycle counter sequences
module tb_isp_counter_bank;
    localparam int BITS = 16;
    localparam int CHANNELS = 4;
    logic clk = 1'b0, reset = 1'b1, valid = 1'b0;
    logic ready, irq;
    logic [7:0] addr = '0;
    logic [3:0] wstrb = '0;
    logic [BITS-1:0] wdata = '0, la_write = '0, la_input = '0;
    logic [BITS-1:0] rdata, count;
    logic [CHANNELS*BITS-1:0] count_flat;
    int total = 0, passed = 0;
    typedef struct {logic chk; logic [15:0] exp; string name;} sb_t;
    typedef struct {logic [3:0] ch; logic [1:0] r; logic [3:0] s; logic [15:0] d; logic [15:0] exp; string name;} vec_t;
    sb_t sbq[$];
    sb_t mon_e;
    vec_t tv[11];
    logic [15:0] mod_seq[6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};

    isp_counter_bank #(.BITS(BITS), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .ready      (ready),
        .addr       (addr),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .rdata      (rdata),
        .la_write   (la_write),
        .la_input   (la_input),
        .count      (count),
        .count_flat (count_flat),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (ready) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got ack expected none");
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.chk) check(mon_e.name, 32'(rdata), 32'(mon_e.exp));
            end
        end
    end

    task automatic txn(input logic [3:0] ch, input logic [1:0] r, input logic [3:0] s,
                       input logic [15:0] d, input logic [15:0] exp, input string name);
        sb_t e;
        int w;
        @(negedge clk);
        addr  = {ch, r, 2'b00};
        wstrb = s;
        wdata = d;
        valid = 1'b1;
        e.chk = (s == 4'h0);
        e.exp = exp;
        e.name = name;
        sbq.push_back(e);
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (!ready && w < 8);
        check({name, "_ack_latency"}, 32'(w), 32'd1);
        if (!ready) sbq.delete(sbq.size() - 1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [1:0] r, input logic [15:0] d);
        txn(ch, r, 4'hF, d, 16'h0, "wr");
    endtask

    task automatic rd(input logic [3:0] ch, input logic [1:0] r, input logic [15:0] exp, input string name);
        txn(ch, r, 4'h0, 16'h0, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{4'd1, 2'd0, 4'h0, 16'h0000, 16'h0000, "ch1_ctrl_rst"};
        tv[1]  = '{4'd1, 2'd1, 4'h0, 16'h0000, 16'h0000, "ch1_count_rst"};
        tv[2]  = '{4'd1, 2'd2, 4'h0, 16'h0000, 16'hFFFF, "ch1_compare_rst"};
        tv[3]  = '{4'd1, 2'd3, 4'h0, 16'h0000, 16'h0000, "ch1_status_rst"};
        tv[4]  = '{4'd9, 2'd2, 4'hF, 16'h1234, 16'h0000, "ch9_wr"};
        tv[5]  = '{4'd9, 2'd2, 4'h0, 16'h0000, 16'h0000, "ch9_compare_rd"};
        tv[6]  = '{4'd1, 2'd2, 4'h0, 16'h0000, 16'hFFFF, "ch1_compare_after_ch9"};
        tv[7]  = '{4'd1, 2'd2, 4'h1, 16'hAB55, 16'h0000, "ch1_cmp_lowbyte_wr"};
        tv[8]  = '{4'd1, 2'd2, 4'h0, 16'h0000, 16'hFF55, "ch1_compare_lowbyte"};
        tv[9]  = '{4'd1, 2'd0, 4'hF, 16'h00FC, 16'h0000, "ch1_ctrl_wr"};
        tv[10] = '{4'd1, 2'd0, 4'h0, 16'h0000, 16'h003C, "ch1_ctrl_rd"};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_count_flat_hi", count_flat[63:32], 32'd0);
        foreach (tv[i]) txn(tv[i].ch, tv[i].r, tv[i].s, tv[i].d, tv[i].exp, tv[i].name);
        // ch0 free-running up across the wrap
        wr(4'd0, 2'd1, 16'hFFFE);
        wr(4'd0, 2'd0, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        check("ch0_wrap_count", 32'(count), 32'd0);
        check("ch0_wrap_flat", 32'(count_flat[15:0]), 32'd0);
        check("ch0_irq_masked", 32'(irq), 32'd0);
        wr(4'd0, 2'd0, 16'h0021);
        check("ch0_irq_ovf_en", 32'(irq), 32'd1);
        rd(4'd0, 2'd3, 16'h0003, "ch0_status_ovf_match");
        wr(4'd0, 2'd3, 16'h0002);
        check("ch0_irq_after_w1c", 32'(irq), 32'd0);
        rd(4'd0, 2'd3, 16'h0001, "ch0_status_after_w1c");
        // LA load on a running ch0, then bus COUNT write against LA
        wr(4'd0, 2'd1, 16'hAB00);
        la_write = 16'h00FF;
        la_input = 16'h1234;
        @(negedge clk);
        check("ch0_la_load", 32'(count), 32'hAB34);
        la_write = '0;
        @(posedge clk);
        #1;
        check("ch0_step_after_la", 32'(count), 32'hAB35);
        la_write = 16'hFFFF;
        la_input = 16'h0000;
        wr(4'd0, 2'd1, 16'h5555);
        check("ch0_bus_beats_la", 32'(count), 32'h5555);
        la_write = '0;
        // ch2 modulo up then down
        wr(4'd2, 2'd2, 16'h0003);
        wr(4'd2, 2'd0, 16'h0005);
        for (int i = 0; i < 6; i++) begin
            check("ch2_modulo_up_seq", 32'(count_flat[2*BITS +: BITS]), 32'(mod_seq[i]));
            @(posedge clk);
            #1;
        end
        rd(4'd2, 2'd3, 16'h0001, "ch2_status_match");
        wr(4'd2, 2'd0, 16'h0004);
        wr(4'd2, 2'd1, 16'h0000);
        wr(4'd2, 2'd3, 16'h0001);
        rd(4'd2, 2'd3, 16'h0000, "ch2_status_cleared");
        wr(4'd2, 2'd0, 16'h0007);
        check("ch2_down_start", 32'(count_flat[2*BITS +: BITS]), 32'd0);
        @(posedge clk);
        #1;
        check("ch2_down_reload", 32'(count_flat[2*BITS +: BITS]), 32'd3);
        @(posedge clk);
        #1;
        check("ch2_down_dec", 32'(count_flat[2*BITS +: BITS]), 32'd2);
        rd(4'd2, 2'd3, 16'h0001, "ch2_status_reload_match");
        // ch3 one-shot
        wr(4'd3, 2'd2, 16'h0005);
        wr(4'd3, 2'd0, 16'h0009);
        repeat (10) @(posedge clk);
        #1;
        check("ch3_oneshot_hold", 32'(count_flat[3*BITS +: BITS]), 32'd5);
        rd(4'd3, 2'd0, 16'h0008, "ch3_ctrl_en_cleared");
        rd(4'd3, 2'd3, 16'h0001, "ch3_status_match");
        rd(4'd3, 2'd1, 16'h0005, "ch3_count_rd");
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
